// File: rtl/d_phy_clock_lane_tx_pkg.sv
// Shared types and default timing for the D-PHY transmit clock lane.
// All durations are in hs_clk cycles (1 cycle = 1 UI).
package d_phy_clock_lane_tx_pkg;

   localparam int WORD_DIV_DEF      = 8;
   localparam int ESC_DIV_DEF       = 16;
   localparam int T_INIT_DEF        = 64;
   localparam int T_LPX_DEF         = 16;
   localparam int T_CLK_PREPARE_DEF = 16;
   localparam int T_CLK_ZERO_DEF    = 64;
   localparam int T_CLK_PRE_DEF     = 8;
   localparam int T_CLK_POST_DEF    = 64;
   localparam int T_CLK_TRAIL_DEF   = 16;
   localparam int T_HS_EXIT_DEF     = 32;
   localparam int T_WAKEUP_DEF      = 256;

   localparam int CNT_W = 16;

   typedef enum logic [3:0] {
      ST_INIT,
      ST_STOP,
      ST_HS_RQST,
      ST_PREPARE,
      ST_HS_ZERO,
      ST_CLK_PRE,
      ST_RUN,
      ST_CLK_POST,
      ST_TRAIL,
      ST_HS_EXIT,
      ST_ULPS_RQST,
      ST_ULPS,
      ST_ULPS_EXIT
   } clk_state_t;

   typedef struct packed {
      logic dp;
      logic dn;
      logic hs_en;
   } line_t;

   function automatic logic is_toggling(clk_state_t s);
      return (s == ST_CLK_PRE) || (s == ST_RUN) || (s == ST_CLK_POST);
   endfunction

   // Static line levels; toggling states are handled by the caller.
   function automatic line_t static_line(clk_state_t s);
      line_t l;
      l = '{dp: 1'b1, dn: 1'b1, hs_en: 1'b0};
      case (s)
         ST_HS_RQST:   l = '{dp: 1'b0, dn: 1'b1, hs_en: 1'b0};
         ST_PREPARE:   l = '{dp: 1'b0, dn: 1'b0, hs_en: 1'b0};
         ST_HS_ZERO:   l = '{dp: 1'b0, dn: 1'b1, hs_en: 1'b1};
         ST_TRAIL:     l = '{dp: 1'b0, dn: 1'b1, hs_en: 1'b1};
         ST_ULPS_RQST: l = '{dp: 1'b1, dn: 1'b0, hs_en: 1'b0};
         ST_ULPS:      l = '{dp: 1'b0, dn: 1'b0, hs_en: 1'b0};
         ST_ULPS_EXIT: l = '{dp: 1'b1, dn: 1'b0, hs_en: 1'b0};
         default:      l = '{dp: 1'b1, dn: 1'b1, hs_en: 1'b0};
      endcase
      return l;
   endfunction

endpackage

// File: rtl/d_phy_clock_lane_tx_if.sv
// PPI bundle between the clock-lane master and its users.
// mcnn/slave are the lane side, master is the controller side.
interface d_phy_full_ppi_if;

   logic enable;
   logic tx_request_hs;
   logic tx_hs_idle_clk_hs;
   logic tx_ulps_clk;
   logic tx_ulps_exit;
   logic tx_word_clk_hs;
   logic esc_tx_clk;
   logic tx_ready_hs;
   logic stopstate;
   logic line_dp;
   logic line_dn;
   logic line_hs_en;

   modport mcnn (
      input  enable, tx_request_hs, tx_hs_idle_clk_hs,
      input  tx_ulps_clk, tx_ulps_exit,
      output tx_word_clk_hs, esc_tx_clk, tx_ready_hs,
      output stopstate, line_dp, line_dn, line_hs_en
   );

   modport slave (
      input  enable, tx_request_hs, tx_hs_idle_clk_hs,
      input  tx_ulps_clk, tx_ulps_exit,
      output tx_word_clk_hs, esc_tx_clk, tx_ready_hs,
      output stopstate, line_dp, line_dn, line_hs_en
   );

   modport master (
      output enable, tx_request_hs, tx_hs_idle_clk_hs,
      output tx_ulps_clk, tx_ulps_exit,
      input  tx_word_clk_hs, esc_tx_clk, tx_ready_hs,
      input  stopstate, line_dp, line_dn, line_hs_en
   );

endinterface

// File: rtl/d_phy_clock_lane_tx_clk_gen.sv
// Word and escape clock dividers derived from the HS bit clock.
// wrap marks the cycle whose following edge is a word boundary.
module d_phy_clk_gen #(
   parameter int WORD_DIV = 8,
   parameter int ESC_DIV  = 16
) (
   input  logic hs_clk,
   input  logic rst_n,
   output logic word_clk,
   output logic esc_clk,
   output logic wrap
);

   localparam int WCW = (WORD_DIV > 2) ? $clog2(WORD_DIV) : 1;
   localparam int EHALF = ESC_DIV / 2;
   localparam int ECW = (EHALF > 1) ? $clog2(EHALF) : 1;

   localparam logic [WCW-1:0] W_HALF = WCW'(WORD_DIV / 2);
   localparam logic [WCW-1:0] W_LAST = WCW'(WORD_DIV - 1);
   localparam logic [ECW-1:0] E_LAST = ECW'(EHALF - 1);

   logic [WCW-1:0] wcnt_q;
   logic [WCW-1:0] wcnt_d;
   logic [ECW-1:0] ecnt_q;

   assign wcnt_d = (wcnt_q == W_LAST) ? '0 : wcnt_q + 1'b1;
   assign wrap   = (wcnt_q == W_LAST);

   // Starting at WORD_DIV/2 puts the first rising edge half a word out.
   always_ff @(posedge hs_clk or negedge rst_n) begin
      if (!rst_n) begin
         wcnt_q   <= W_HALF;
         word_clk <= 1'b0;
      end else begin
         wcnt_q   <= wcnt_d;
         word_clk <= (wcnt_d < W_HALF);
      end
   end

   always_ff @(posedge hs_clk or negedge rst_n) begin
      if (!rst_n) begin
         ecnt_q  <= '0;
         esc_clk <= 1'b0;
      end else if (ecnt_q == E_LAST) begin
         ecnt_q  <= '0;
         esc_clk <= ~esc_clk;
      end else begin
         ecnt_q  <= ecnt_q + 1'b1;
      end
   end

endmodule

// File: rtl/d_phy_clock_lane_tx.sv
// D-PHY transmit clock-lane master: state machine and line drivers.
// Outputs are registered from the current state, one cycle behind it.
module d_phy_clock_lane_tx
   import d_phy_clock_lane_tx_pkg::*;
#(
   parameter int WORD_DIV      = WORD_DIV_DEF,
   parameter int ESC_DIV       = ESC_DIV_DEF,
   parameter int T_INIT        = T_INIT_DEF,
   parameter int T_LPX         = T_LPX_DEF,
   parameter int T_CLK_PREPARE = T_CLK_PREPARE_DEF,
   parameter int T_CLK_ZERO    = T_CLK_ZERO_DEF,
   parameter int T_CLK_PRE     = T_CLK_PRE_DEF,
   parameter int T_CLK_POST    = T_CLK_POST_DEF,
   parameter int T_CLK_TRAIL   = T_CLK_TRAIL_DEF,
   parameter int T_HS_EXIT     = T_HS_EXIT_DEF,
   parameter int T_WAKEUP      = T_WAKEUP_DEF
) (
   input logic hs_clk,
   input logic rst_n,
   d_phy_full_ppi_if.mcnn ppi
);

   clk_state_t state_q;
   clk_state_t state_d;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic done;
   logic wrap;
   logic word_clk;
   logic esc_clk;
   logic ready_q;
   logic stop_q;
   logic tog_q;
   line_t line_q;

   d_phy_clk_gen #(
      .WORD_DIV (WORD_DIV),
      .ESC_DIV  (ESC_DIV)
   ) u_clk_gen (
      .hs_clk   (hs_clk),
      .rst_n    (rst_n),
      .word_clk (word_clk),
      .esc_clk  (esc_clk),
      .wrap     (wrap)
   );

   function automatic logic [CNT_W-1:0] reload(clk_state_t s);
      logic [CNT_W-1:0] v;
      v = '0;
      case (s)
         ST_INIT:      v = CNT_W'(T_INIT - 1);
         ST_HS_RQST:   v = CNT_W'(T_LPX - 1);
         ST_PREPARE:   v = CNT_W'(T_CLK_PREPARE - 1);
         ST_HS_ZERO:   v = CNT_W'(T_CLK_ZERO - 1);
         ST_CLK_PRE:   v = CNT_W'(T_CLK_PRE - 1);
         ST_CLK_POST:  v = CNT_W'(T_CLK_POST - 1);
         ST_TRAIL:     v = CNT_W'(T_CLK_TRAIL - 1);
         ST_HS_EXIT:   v = CNT_W'(T_HS_EXIT - 1);
         ST_ULPS_RQST: v = CNT_W'(T_LPX - 1);
         ST_ULPS_EXIT: v = CNT_W'(T_WAKEUP - 1);
         default:      v = '0;
      endcase
      return v;
   endfunction

   assign done = (cnt_q == '0);

   always_ff @(posedge hs_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_INIT;
         cnt_q   <= CNT_W'(T_INIT - 1);
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = done ? '0 : cnt_q - 1'b1;
      if (!ppi.enable) begin
         state_d = ST_INIT;
      end else begin
         unique case (state_q)
            ST_INIT:      if (done) state_d = ST_STOP;
            ST_STOP: begin
               if (ppi.tx_request_hs)    state_d = ST_HS_RQST;
               else if (ppi.tx_ulps_clk) state_d = ST_ULPS_RQST;
            end
            ST_HS_RQST:   if (done) state_d = ST_PREPARE;
            ST_PREPARE:   if (done) state_d = ST_HS_ZERO;
            ST_HS_ZERO:   if (done) state_d = ST_CLK_PRE;
            ST_CLK_PRE: begin
               if (done)
                  state_d = ppi.tx_request_hs ? ST_RUN : ST_CLK_POST;
            end
            ST_RUN: begin
               if (!ppi.tx_request_hs && !ppi.tx_hs_idle_clk_hs)
                  state_d = ST_CLK_POST;
            end
            ST_CLK_POST:  if (done) state_d = ST_TRAIL;
            ST_TRAIL:     if (done) state_d = ST_HS_EXIT;
            ST_HS_EXIT:   if (done) state_d = ST_STOP;
            ST_ULPS_RQST: if (done) state_d = ST_ULPS;
            ST_ULPS:      if (ppi.tx_ulps_exit) state_d = ST_ULPS_EXIT;
            ST_ULPS_EXIT: begin
               if (done && !ppi.tx_ulps_exit) state_d = ST_STOP;
            end
            default:      state_d = ST_INIT;
         endcase
      end
      // Holding enable low keeps INIT's count reloaded.
      if (state_d != state_q || !ppi.enable)
         cnt_d = reload(state_d);
   end

   always_ff @(posedge hs_clk or negedge rst_n) begin
      if (!rst_n) begin
         line_q  <= '{dp: 1'b1, dn: 1'b1, hs_en: 1'b0};
         tog_q   <= 1'b0;
         stop_q  <= 1'b0;
         ready_q <= 1'b0;
      end else if (!ppi.enable) begin
         line_q  <= '{dp: 1'b1, dn: 1'b1, hs_en: 1'b0};
         tog_q   <= 1'b0;
         stop_q  <= 1'b0;
         ready_q <= 1'b0;
      end else begin
         stop_q <= (state_q == ST_STOP);
         if (wrap)
            ready_q <= (state_q == ST_RUN) && ppi.tx_request_hs;
         if (is_toggling(state_q)) begin
            tog_q        <= 1'b1;
            line_q.hs_en <= 1'b1;
            line_q.dp    <= tog_q ? ~line_q.dp : 1'b1;
            line_q.dn    <= tog_q ? line_q.dp : 1'b0;
         end else begin
            tog_q  <= 1'b0;
            line_q <= static_line(state_q);
         end
      end
   end

   assign ppi.tx_word_clk_hs = word_clk;
   assign ppi.esc_tx_clk     = esc_clk;
   assign ppi.tx_ready_hs    = ready_q;
   assign ppi.stopstate      = stop_q;
   assign ppi.line_dp        = line_q.dp;
   assign ppi.line_dn        = line_q.dn;
   assign ppi.line_hs_en     = line_q.hs_en;

endmodule

// File: tb/tb_d_phy_clock_lane_tx.sv
// Directed bench for the D-PHY clock lane; cycle c = state after the
// c-th rising edge following reset release, sampled 1 time unit later.
module tb_d_phy_clock_lane_tx;

   logic hs_clk;
   logic rst_n;
   int   cyc;
   int   vectors;
   int   miscompares;
   logic [2:0] ln;

   d_phy_full_ppi_if ppi ();

   d_phy_clock_lane_tx dut (
      .hs_clk (hs_clk),
      .rst_n  (rst_n),
      .ppi    (ppi)
   );

   assign ln = {ppi.line_dp, ppi.line_dn, ppi.line_hs_en};

   initial hs_clk = 1'b0;
   always #5 hs_clk = ~hs_clk;

   task automatic step();
      @(posedge hs_clk);
      #1;
      cyc++;
   endtask

   task automatic goto(input int c);
      while (cyc < c) step();
   endtask

   task automatic check(input string tag, input logic [7:0] obs,
                        input logic [7:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s @cyc %0d: observed %0h expected %0h",
                tag, cyc, obs, exp);
      end
   endtask

   initial begin
      vectors = 0;
      miscompares = 0;
      cyc = 0;
      rst_n = 1'b0;
      ppi.enable = 1'b1;
      ppi.tx_request_hs = 1'b0;
      ppi.tx_hs_idle_clk_hs = 1'b0;
      ppi.tx_ulps_clk = 1'b0;
      ppi.tx_ulps_exit = 1'b0;

      repeat (3) @(posedge hs_clk);
      #1;
      check("rst_line", 8'(ln), 8'b110);
      check("rst_word", 8'(ppi.tx_word_clk_hs), 8'd0);
      check("rst_esc", 8'(ppi.esc_tx_clk), 8'd0);
      check("rst_ready", 8'(ppi.tx_ready_hs), 8'd0);
      check("rst_stop", 8'(ppi.stopstate), 8'd0);
      rst_n = 1'b1;
      cyc = 0;

      // Init and clock dividers
      goto(3);  check("word_c3", 8'(ppi.tx_word_clk_hs), 8'd0);
      goto(4);  check("word_c4", 8'(ppi.tx_word_clk_hs), 8'd1);
      goto(7);  check("esc_c7", 8'(ppi.esc_tx_clk), 8'd0);
      goto(8);  check("esc_c8", 8'(ppi.esc_tx_clk), 8'd1);
      check("word_c8", 8'(ppi.tx_word_clk_hs), 8'd0);
      goto(64); check("stop_c64", 8'(ppi.stopstate), 8'd0);
      goto(65); check("stop_c65", 8'(ppi.stopstate), 8'd1);
      check("line_stop", 8'(ln), 8'b110);

      // Single burst
      ppi.tx_request_hs = 1'b1;
      goto(66);  check("b_stop_c66", 8'(ppi.stopstate), 8'd1);
      goto(67);  check("b_lp01", 8'(ln), 8'b010);
      check("b_stop_c67", 8'(ppi.stopstate), 8'd0);
      goto(82);  check("b_lp01_end", 8'(ln), 8'b010);
      goto(83);  check("b_lp00", 8'(ln), 8'b000);
      goto(99);  check("b_hs0", 8'(ln), 8'b011);
      goto(162); check("b_hs0_end", 8'(ln), 8'b011);
      goto(163); check("b_tog1", 8'(ln), 8'b101);
      goto(164); check("b_tog2", 8'(ln), 8'b011);
      goto(171); check("b_rdy_c171", 8'(ppi.tx_ready_hs), 8'd0);
      goto(172); check("b_rdy_c172", 8'(ppi.tx_ready_hs), 8'd1);
      goto(180); check("b_run_even", 8'(ln), 8'b011);
      ppi.tx_request_hs = 1'b0;
      goto(187); check("b_rdy_c187", 8'(ppi.tx_ready_hs), 8'd1);
      goto(188); check("b_rdy_c188", 8'(ppi.tx_ready_hs), 8'd0);
      goto(245); check("b_post_last", 8'(ln), 8'b101);
      goto(246); check("b_trail", 8'(ln), 8'b011);
      goto(261); check("b_trail_end", 8'(ln), 8'b011);
      goto(262); check("b_exit", 8'(ln), 8'b110);
      goto(293); check("b_stop_c293", 8'(ppi.stopstate), 8'd0);
      goto(294); check("b_stop_c294", 8'(ppi.stopstate), 8'd1);

      // Request pulse dropped during PREPARE
      ppi.tx_request_hs = 1'b1;
      goto(315);
      check("p_prepare", 8'(ln), 8'b000);
      ppi.tx_request_hs = 1'b0;
      for (int c = 316; c <= 512; c++) begin
         goto(c);
         check("p_no_ready", 8'(ppi.tx_ready_hs), 8'd0);
      end
      // cycle 512 reached inside the loop
      check("p_stop_c512", 8'(ppi.stopstate), 8'd1);

      // Idle clock across a request drop
      ppi.tx_request_hs = 1'b1;
      ppi.tx_hs_idle_clk_hs = 1'b1;
      goto(619); check("i_rdy_c619", 8'(ppi.tx_ready_hs), 8'd0);
      goto(620); check("i_rdy_c620", 8'(ppi.tx_ready_hs), 8'd1);
      ppi.tx_request_hs = 1'b0;
      goto(627); check("i_rdy_c627", 8'(ppi.tx_ready_hs), 8'd1);
      goto(628); check("i_rdy_c628", 8'(ppi.tx_ready_hs), 8'd0);
      goto(640); check("i_still_hs", 8'(ppi.line_hs_en), 8'd1);
      ppi.tx_request_hs = 1'b1;
      goto(643); check("i_rdy_c643", 8'(ppi.tx_ready_hs), 8'd0);
      goto(644); check("i_rdy_c644", 8'(ppi.tx_ready_hs), 8'd1);
      goto(650);
      ppi.tx_request_hs = 1'b0;
      ppi.tx_hs_idle_clk_hs = 1'b0;
      goto(652); check("i_rdy_c652", 8'(ppi.tx_ready_hs), 8'd0);
      goto(763); check("i_stop_c763", 8'(ppi.stopstate), 8'd0);
      goto(764); check("i_stop_c764", 8'(ppi.stopstate), 8'd1);

      // ULPS entry and exit
      ppi.tx_ulps_clk = 1'b1;
      goto(766); check("u_lp10", 8'(ln), 8'b100);
      check("u_stop", 8'(ppi.stopstate), 8'd0);
      goto(781); check("u_lp10_end", 8'(ln), 8'b100);
      goto(782); check("u_lp00", 8'(ln), 8'b000);
      goto(790);
      ppi.tx_ulps_clk = 1'b0;
      goto(800); check("u_hold", 8'(ln), 8'b000);
      ppi.tx_ulps_exit = 1'b1;
      goto(802); check("u_wake", 8'(ln), 8'b100);
      goto(810);
      ppi.tx_ulps_exit = 1'b0;
      goto(1057); check("u_wake_end", 8'(ln), 8'b100);
      check("u_stop_c1057", 8'(ppi.stopstate), 8'd0);
      goto(1058); check("u_stop_c1058", 8'(ppi.stopstate), 8'd1);
      check("u_lp11", 8'(ln), 8'b110);

      // enable dropped mid-RUN
      ppi.tx_request_hs = 1'b1;
      goto(1163); check("e_rdy_c1163", 8'(ppi.tx_ready_hs), 8'd0);
      goto(1164); check("e_rdy_c1164", 8'(ppi.tx_ready_hs), 8'd1);
      goto(1170); check("e_hs_on", 8'(ppi.line_hs_en), 8'd1);
      ppi.enable = 1'b0;
      ppi.tx_request_hs = 1'b0;
      goto(1171);
      check("e_line", 8'(ln), 8'b110);
      check("e_ready", 8'(ppi.tx_ready_hs), 8'd0);
      check("e_stop", 8'(ppi.stopstate), 8'd0);
      goto(1175);
      ppi.enable = 1'b1;
      goto(1239); check("e_stop_c1239", 8'(ppi.stopstate), 8'd0);
      goto(1240); check("e_stop_c1240", 8'(ppi.stopstate), 8'd1);

      // Asynchronous reset mid-burst
      ppi.tx_request_hs = 1'b1;
      goto(1350); check("r_hs_on", 8'(ppi.line_hs_en), 8'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("r_line", 8'(ln), 8'b110);
      check("r_ready", 8'(ppi.tx_ready_hs), 8'd0);
      check("r_stop", 8'(ppi.stopstate), 8'd0);
      check("r_word", 8'(ppi.tx_word_clk_hs), 8'd0);
      check("r_esc", 8'(ppi.esc_tx_clk), 8'd0);

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
